// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding uart_tx via en/busy handshake; optional LF->CRLF via UART_TX_FIFO_CRLF_EN
module uart_tx_fifo #(
    parameter int DEPTH_LOG2    = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  cpu_clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  ovf_clr,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  drain_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [SW-1:0]       SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, SETTLE} state_t;

    state_t                r_state;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic [SW-1:0]         r_settle;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_ovf;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_empty;
    logic [DEPTH_LOG2+1:0] w_space;
    logic [DEPTH_LOG2:0]   w_inc;

    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == IDLE) && !w_empty && !tx_busy;
    // free entries this cycle, counting the slot released by a same-cycle pop
    assign w_space = {1'b0, FULL_CNT - r_count} + {{(DEPTH_LOG2 + 1){1'b0}}, w_pop};

`ifdef UART_TX_FIFO_CRLF_EN
    logic                  w_lf;
    logic [DEPTH_LOG2+1:0] w_need;
    logic [DEPTH_LOG2-1:0] w_wp_nxt;

    assign w_lf     = (wr_data == 8'h0A);
    assign w_need   = w_lf ? (DEPTH_LOG2 + 2)'(2) : (DEPTH_LOG2 + 2)'(1);
    assign w_push   = wr_en && (w_space >= w_need);
    assign w_inc    = w_push ? (w_lf ? (DEPTH_LOG2 + 1)'(2) : (DEPTH_LOG2 + 1)'(1)) : '0;
    assign w_wp_nxt = r_wp + 1'b1;
`else
    assign w_push = wr_en && (w_space != '0);
    assign w_inc  = {{DEPTH_LOG2{1'b0}}, w_push};
`endif

    always_ff @(posedge cpu_clk) begin
        if (w_push) begin
`ifdef UART_TX_FIFO_CRLF_EN
            if (w_lf) begin
                r_mem[r_wp]     <= 8'h0D;
                r_mem[w_wp_nxt] <= 8'h0A;
            end else begin
                r_mem[r_wp] <= wr_data;
            end
`else
            r_mem[r_wp] <= wr_data;
`endif
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_settle   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_ovf      <= 1'b0;
        end else begin
            r_count    <= r_count + w_inc - {{DEPTH_LOG2{1'b0}}, w_pop};
            r_wp       <= r_wp + w_inc[DEPTH_LOG2-1:0];
            r_tx_start <= 1'b0;

            if (wr_en && !w_push) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            // tx_busy is only sampled in IDLE, so uart_tx may raise busy a cycle late
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_mem[r_rp];
                        r_rp       <= r_rp + 1'b1;
                        r_settle   <= SETTLE_INIT;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= (r_settle == '0) ? IDLE : SETTLE;
                end
                SETTLE: begin
                    r_settle <= r_settle - 1'b1;
                    if (r_settle <= SW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign full       = (r_count == FULL_CNT);
    assign empty      = w_empty;
    assign level      = r_count;
    assign overflow   = r_ovf;
    assign drain_busy = !w_empty || (r_state != IDLE) || tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo (CRLF cases under UART_TX_FIFO_CRLF_EN)
module tb_uart_tx_fifo;

    logic       cpu_clk = 1'b0;
    logic       rstn    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       overflow;
    logic       drain_busy;

    always #5 cpu_clk = ~cpu_clk;

    uart_tx_fifo #(.DEPTH_LOG2(3), .SETTLE_CYCLES(2)) dut (
        .cpu_clk    (cpu_clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .drain_busy (drain_busy)
    );

    typedef struct packed {
        logic       ts;
        logic [7:0] td;
        logic [3:0] lvl;
        logic       fu;
        logic       em;
        logic       ov;
        logic       dr;
    } outs_t;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       clr;
        logic       busy;
        outs_t      want;
    } vec_t;

    int         n_chk = 0;
    int         n_err = 0;
    vec_t       vt[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         max_level = 0;
    logic       prev_ts = 1'b0;
    logic       bm_en = 1'b0;
    int         bm_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    function automatic outs_t cur();
        return {tx_start, tx_data, level, full, empty, overflow, drain_busy};
    endfunction

    function automatic vec_t mk(logic we, logic [7:0] wd, logic clr, logic busy,
                                logic ts, logic [7:0] td, int lvl, logic fu, logic em,
                                logic ov, logic dr);
        vec_t v;
        v.we = we; v.wd = wd; v.clr = clr; v.busy = busy;
        v.want = {ts, td, 4'(lvl), fu, em, ov, dr};
        return v;
    endfunction

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (empty && !drain_busy) break;
            step();
        end
        chk("drain_idle", {30'd0, empty, drain_busy}, 32'h2);
    endtask

    task automatic cmp_q(input string name);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
    endtask

    // launch monitor: collects emitted bytes, checks single-cycle pulses, tracks peak level
    initial begin
        forever begin
            @(posedge cpu_clk);
            #1;
            if (tx_start) begin
                chk("ts_one_cycle", prev_ts, 0);
                got_q.push_back(tx_data);
            end
            prev_ts = tx_start;
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    // uart_tx busy model: busy for 10 cycles after each launch
    initial begin
        forever begin
            @(posedge cpu_clk);
            #1;
            if (bm_en) begin
                if (tx_start) bm_cnt = 10;
                if (bm_cnt > 0) begin
                    tx_busy = 1'b1;
                    bm_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int need;

        vt.push_back(mk(1, 8'h41, 0, 0,  0, 8'h00, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0,  1, 8'h41, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0,  0, 8'h41, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0,  0, 8'h41, 0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1, 8'h31 + 8'(i), 0, 1,  0, 8'h41, i + 1, (i == 7), 0, 0, 1));
        vt.push_back(mk(1, 8'h39, 0, 1,  0, 8'h41, 8, 1, 0, 1, 1));
        vt.push_back(mk(0, 8'h00, 1, 1,  0, 8'h41, 8, 1, 0, 0, 1));
        vt.push_back(mk(1, 8'h3A, 1, 1,  0, 8'h41, 8, 1, 0, 1, 1));

        rstn = 1'b0;
        step();
        step();
        chk("reset_state", cur(), outs_t'({1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
        rstn = 1'b1;

        for (int k = 0; k < vt.size(); k++) begin
            wr_en = vt[k].we; wr_data = vt[k].wd; ovf_clr = vt[k].clr; tx_busy = vt[k].busy;
            step();
            chk($sformatf("vec%0d", k), cur(), vt[k].want);
        end
        wr_en = 1'b0; ovf_clr = 1'b0;

        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h31 + 8'(i));
        tx_busy = 1'b0;
        wait_drain(100);
        cmp_q("burst");
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        got_q.delete();
        exp_q.delete();
        max_level = 0;
        bm_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            need = 1;
`ifdef UART_TX_FIFO_CRLF_EN
            if (i == 10) need = 2;
`endif
            for (int w = 0; w < 50 && int'(level) > 8 - need; w++) step();
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            wr_en = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
            if (i == 10) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(8'(i));
        end
        for (int w = 0; w < 1000 && got_q.size() < exp_q.size(); w++) step();
        wait_drain(50);
        bm_en = 1'b0;
        step();
        tx_busy = 1'b0;
        cmp_q("wrap");
        chk("wrap_max_level", (max_level <= 8), 1);
        chk("wrap_ovf", overflow, 0);

        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("fill8", cur(), outs_t'({1'b0, 8'h13, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1}));
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'hA0 + 8'(i));
        tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hA8;
        step();
        wr_en = 1'b0;
        chk("pop_push_full", cur(), outs_t'({1'b1, 8'hA0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1}));
        wait_drain(100);
        cmp_q("pop_push_order");
        chk("pop_push_ovf", overflow, 0);

        tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        tx_busy = 1'b0;
        repeat (8) step();
        chk("pre_reset", {level, overflow, drain_busy, tx_start}, {4'd5, 1'b1, 1'b1, 1'b0});
        tx_busy = 1'b1; rstn = 1'b0;
        step();
        chk("reset_mid", cur(), outs_t'({1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1}));
        rstn = 1'b1; tx_busy = 1'b0;
        #1;
        chk("reset_drain_busy", drain_busy, 0);
        step();
        chk("post_reset", cur(), outs_t'({1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

`ifdef UART_TX_FIFO_CRLF_EN
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        wr_en = 1'b1; wr_data = 8'h0A;
        step();
        wr_en = 1'b0;
        chk("crlf_level", level, 2);
        wait_drain(100);
        cmp_q("crlf_order");
        tx_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            step();
        end
        chk("crlf_lvl7", level, 7);
        wr_data = 8'h0A;
        step();
        wr_en = 1'b0;
        chk("crlf_drop", {level, overflow}, {4'd7, 1'b1});
        tx_busy = 1'b0;
        wait_drain(100);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
